// File: rtl/memory_request_arbiter.sv
// memory_request_arbiter
//   Front end of the byte-serial memory interface. It arbitrates between the
//   instruction-fetch requester (port 0) and the load/store requester (port 1).
//   It issues one transaction at a time to the interface and returns the read
//   word together with a one-cycle ack to the port that won.
//
//   Optional build macro: ARBITER_ROUND_ROBIN_EN
//     defined   : round-robin on simultaneous requests, tracked by lastGrant
//     undefined : fixed priority, load/store (port 1) beats fetch (port 0)
module memory_request_arbiter #(
  parameter int ADDRESS_BUS_WIDTH  = 32,
  parameter int DATA_WIDTH         = 32,
  parameter int CLOCK_COUNT_WIDTH  = 3,
  parameter int MEMORY_CLOCK_COUNT = 2,
  parameter int IO_CLOCK_COUNT     = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req0,
  input  logic                         req1,
  input  logic [ADDRESS_BUS_WIDTH-1:0] address0,
  input  logic [ADDRESS_BUS_WIDTH-1:0] address1,
  input  logic [DATA_WIDTH-1:0]        dataIn0,
  input  logic [DATA_WIDTH-1:0]        dataIn1,
  input  logic                         readWrite0,
  input  logic                         readWrite1,
  input  logic                         isMemory0,
  input  logic                         isMemory1,
  output logic                         ack0,
  output logic                         ack1,
  output logic [DATA_WIDTH-1:0]        respData,
  output logic                         busy,
  output logic [ADDRESS_BUS_WIDTH-1:0] ifAddress,
  output logic [DATA_WIDTH-1:0]        ifDataIn,
  output logic                         ifReadWrite,
  output logic                         ifIsMemory,
  output logic [CLOCK_COUNT_WIDTH-1:0] ifClockCount,
  output logic                         ifEnable,
  input  logic                         ifReady,
  input  logic [DATA_WIDTH-1:0]        ifDataOut
);

  localparam logic [CLOCK_COUNT_WIDTH-1:0] MEM_COUNT = CLOCK_COUNT_WIDTH'(MEMORY_CLOCK_COUNT);
  localparam logic [CLOCK_COUNT_WIDTH-1:0] IO_COUNT  = CLOCK_COUNT_WIDTH'(IO_CLOCK_COUNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t nextState;

  logic grantSel;   // port chosen this cycle when in IDLE (1 = load/store)
  logic grantPort;  // port owning the transaction in flight
  logic anyReq;

  assign anyReq = req0 | req1;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic lastGrant;

  // Contested requests go to the port that did not win last time
  always_comb begin
    grantSel = req1;
    if (req0 && req1) grantSel = ~lastGrant;
  end

  // Remember the most recent winner, updated only at grant
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                         lastGrant <= 1'b0;
    else if (state == S_IDLE && anyReq) lastGrant <= grantSel;
  end
`else
  // Load/store always wins over fetch when both are pending
  always_comb begin
    grantSel = req1;
  end
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nextState;
  end

  // Next-state decode and state-derived control outputs
  always_comb begin
    nextState = state;
    ifEnable  = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (anyReq) nextState = S_ISSUE;
      end
      S_ISSUE: begin
        // A ready left over from the previous transaction is ignored here
        ifEnable  = 1'b1;
        nextState = S_WAIT;
      end
      S_WAIT: begin
        if (ifReady) nextState = S_DONE;
      end
      S_DONE: begin
        ack0      = ~grantPort;
        ack1      = grantPort;
        nextState = S_IDLE;
      end
      default: nextState = S_IDLE;
    endcase
  end

  // Capture the winner's request fields at grant; held until the next grant
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grantPort    <= 1'b0;
      ifAddress    <= '0;
      ifDataIn     <= '0;
      ifReadWrite  <= 1'b0;
      ifIsMemory   <= 1'b0;
      ifClockCount <= '0;
    end else if (state == S_IDLE && anyReq) begin
      grantPort    <= grantSel;
      ifAddress    <= grantSel ? address1   : address0;
      ifDataIn     <= grantSel ? dataIn1    : dataIn0;
      ifReadWrite  <= grantSel ? readWrite1 : readWrite0;
      ifIsMemory   <= grantSel ? isMemory1  : isMemory0;
      if (grantSel ? isMemory1 : isMemory0) ifClockCount <= MEM_COUNT;
      else                                  ifClockCount <= IO_COUNT;
    end
  end

  // Latch the read word when the interface completes a read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                       respData <= '0;
    else if (state == S_WAIT && ifReady && ifReadWrite) respData <= ifDataOut;
  end

endmodule

// File: tb/tb_memory_request_arbiter.sv
// tb_memory_request_arbiter
//   Directed bench for memory_request_arbiter. The bench plays the
//   interface side by hand and checks every transaction field, the
//   enable pulse, ack timing and the returned read word.
module tb_memory_request_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] address0, address1, dataIn0, dataIn1;
  logic        readWrite0, readWrite1, isMemory0, isMemory1;
  logic        ack0, ack1, busy;
  logic [31:0] respData, ifAddress, ifDataIn;
  logic        ifReadWrite, ifIsMemory, ifEnable;
  logic [2:0]  ifClockCount;
  logic        ifReady;
  logic [31:0] ifDataOut;

  int vectors     = 0;
  int miscompares = 0;

  memory_request_arbiter dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1),
    .address0(address0), .address1(address1),
    .dataIn0(dataIn0), .dataIn1(dataIn1),
    .readWrite0(readWrite0), .readWrite1(readWrite1),
    .isMemory0(isMemory0), .isMemory1(isMemory1),
    .ack0(ack0), .ack1(ack1), .respData(respData), .busy(busy),
    .ifAddress(ifAddress), .ifDataIn(ifDataIn),
    .ifReadWrite(ifReadWrite), .ifIsMemory(ifIsMemory),
    .ifClockCount(ifClockCount), .ifEnable(ifEnable),
    .ifReady(ifReady), .ifDataOut(ifDataOut)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Serve one granted transaction; returns at the negedge after the ack cycle
  task automatic serve(input bit port, input logic [31:0] addr, input logic [31:0] data,
                       input bit rw, input bit mem, input logic [2:0] cc,
                       input logic [31:0] rdata, input logic [31:0] expResp,
                       input int waitCycles, input bit stale);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clock);
      if (ifEnable) seen = 1'b1;
    end
    check("enable_seen", {31'd0, seen}, 32'd1);
    if (!seen) return;
    check("if_address", ifAddress, addr);
    check("if_datain", ifDataIn, data);
    check("if_readwrite", {31'd0, ifReadWrite}, {31'd0, rw});
    check("if_ismemory", {31'd0, ifIsMemory}, {31'd0, mem});
    check("if_clockcount", {29'd0, ifClockCount}, {29'd0, cc});
    check("busy_issue", {31'd0, busy}, 32'd1);
    if (stale) begin
      ifReady   = 1'b1;
      ifDataOut = 32'hBAD0BAD0;
    end else begin
      ifReady = 1'b0;
    end
    @(negedge clock);
    check("enable_pulse", {31'd0, ifEnable}, 32'd0);
    check("no_early_ack", {30'd0, ack0, ack1}, 32'd0);
    ifReady = 1'b0;
    for (int i = 0; i < waitCycles; i++) begin
      @(negedge clock);
      check("wait_no_ack", {30'd0, ack0, ack1}, 32'd0);
      check("wait_hold_addr", ifAddress, addr);
      check("wait_hold_data", ifDataIn, data);
    end
    ifReady   = 1'b1;
    ifDataOut = rdata;
    @(negedge clock);
    check("ack0", {31'd0, ack0}, {31'd0, ~port});
    check("ack1", {31'd0, ack1}, {31'd0, port});
    check("resp_data", respData, expResp);
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
    @(negedge clock);
    check("ack_one_cycle", {30'd0, ack0, ack1}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset = 1'b0;
    req0 = 0; req1 = 0;
    address0 = 0; address1 = 0; dataIn0 = 0; dataIn1 = 0;
    readWrite0 = 0; readWrite1 = 0; isMemory0 = 0; isMemory1 = 0;
    ifReady = 0; ifDataOut = 0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_enable", {31'd0, ifEnable}, 32'd0);
    check("rst_acks", {30'd0, ack0, ack1}, 32'd0);
    check("rst_resp", respData, 32'd0);
    check("rst_addr", ifAddress, 32'd0);
    check("rst_cc", {29'd0, ifClockCount}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_no_req", {31'd0, busy}, 32'd0);

    // Reset mid-WAIT aborts the transaction
    req0 = 1; address0 = 32'h0000_0700; readWrite0 = 1; isMemory0 = 1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clock);
      if (ifEnable) seen = 1'b1;
    end
    check("abort_enable_seen", {31'd0, seen}, 32'd1);
    repeat (2) @(negedge clock);
    check("abort_busy_wait", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    req0  = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_enable", {31'd0, ifEnable}, 32'd0);
    check("abort_acks", {30'd0, ack0, ack1}, 32'd0);
    check("abort_addr", ifAddress, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("abort_stay_idle", {29'd0, busy, ack0, ack1}, 32'd0);
    end

    // Fetch read from memory
    req0 = 1; address0 = 32'h0000_0100; dataIn0 = 0; readWrite0 = 1; isMemory0 = 1;
    serve(1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 3'd2, 32'hDEADBEEF, 32'hDEADBEEF, 8, 1'b0);

    // Load/store write to IO; read word must not change
    req1 = 1; address1 = 32'h0000_2000; dataIn1 = 32'h12345678; readWrite1 = 0; isMemory1 = 0;
    serve(1'b1, 32'h2000, 32'h12345678, 1'b0, 1'b0, 3'd5, 32'h55AA55AA, 32'hDEADBEEF, 10, 1'b0);

    // Stale ready held through ISSUE must not complete the transaction early
    req0 = 1; address0 = 32'h0000_0140; dataIn0 = 0; readWrite0 = 1; isMemory0 = 1;
    serve(1'b0, 32'h140, 32'h0, 1'b1, 1'b1, 3'd2, 32'hA5A50001, 32'hA5A50001, 3, 1'b1);

    // Fresh reset so arbitration history starts from port 0
    reset = 1'b0;
    ifReady = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

`ifdef ARBITER_ROUND_ROBIN_EN
    // Both requesters held: grants alternate starting with port 1
    req0 = 1; address0 = 32'h0000_6000; dataIn0 = 0; readWrite0 = 1; isMemory0 = 0;
    req1 = 1; address1 = 32'h0000_5000; dataIn1 = 0; readWrite1 = 1; isMemory1 = 1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        serve(1'b1, 32'h5000, 32'h0, 1'b1, 1'b1, 3'd2, 32'h1000 + i, 32'h1000 + i, 2, 1'b0);
        req1 = 1'b1;
      end else begin
        serve(1'b0, 32'h6000, 32'h0, 1'b1, 1'b0, 3'd5, 32'h1000 + i, 32'h1000 + i, 2, 1'b0);
        req0 = 1'b1;
      end
    end
    req0 = 1'b0;
    serve(1'b1, 32'h5000, 32'h0, 1'b1, 1'b1, 3'd2, 32'h2000, 32'h2000, 2, 1'b0);
`else
    // Simultaneous requests: port 1 first, then port 0
    req0 = 1; address0 = 32'h0000_0400; dataIn0 = 0; readWrite0 = 1; isMemory0 = 0;
    req1 = 1; address1 = 32'h0000_3000; dataIn1 = 32'hFEEDFACE; readWrite1 = 0; isMemory1 = 1;
    serve(1'b1, 32'h3000, 32'hFEEDFACE, 1'b0, 1'b1, 3'd2, 32'h77777777, 32'h0, 4, 1'b0);
    serve(1'b0, 32'h400, 32'h0, 1'b1, 1'b0, 3'd5, 32'hCAFEF00D, 32'hCAFEF00D, 4, 1'b0);
`endif

    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("final_idle", {29'd0, busy, ack0, ack1}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
